// File: rtl/regfile_if.sv
// regfile_if: ID read ports, EX/MEM/WB bypass inputs and operand results
interface regfile_if;
    logic [4:0]  id_rsAddr;
    logic [4:0]  id_rtAddr;
    logic [4:0]  ex_regDest;
    logic [31:0] ex_value;
    logic        ex_isLoad;
    logic [4:0]  mem_regDest;
    logic [31:0] mem_value;
    logic [4:0]  wb_regDest;
    logic [31:0] wb_value;
    logic [31:0] id_rsValue;
    logic [31:0] id_rtValue;
    logic        id_stall;
    modport master (
        output id_rsAddr, id_rtAddr, ex_regDest, ex_value, ex_isLoad,
               mem_regDest, mem_value, wb_regDest, wb_value,
        input  id_rsValue, id_rtValue, id_stall
    );
    modport slave (
        input  id_rsAddr, id_rtAddr, ex_regDest, ex_value, ex_isLoad,
               mem_regDest, mem_value, wb_regDest, wb_value,
        output id_rsValue, id_rtValue, id_stall
    );
endinterface

// File: rtl/regfile.sv
// regfile: 31x32 register storage with EX/MEM/WB operand bypass and load-use stall
module regfile (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    logic [31:0] r [31:1];
    logic [4:0]  addr [2];
    logic [31:0] val [2];
    logic        haz [2];
    assign addr[0] = bus.id_rsAddr;
    assign addr[1] = bus.id_rtAddr;
    // commit writeback; destination 0 means no write, reset wins over a write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) r[i] <= '0;
        end else if (bus.wb_regDest != 5'd0) begin
            r[bus.wb_regDest] <= bus.wb_value;
        end
    end
    // per-port read: youngest producer wins (EX > MEM > WB > storage)
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            haz[i] = 1'b0;
            if (addr[i] == 5'd0) begin
                val[i] = '0;
            end else if (addr[i] == bus.ex_regDest) begin
                val[i] = bus.ex_value;
                haz[i] = bus.ex_isLoad;
            end else if (addr[i] == bus.mem_regDest) begin
                val[i] = bus.mem_value;
            end else if (addr[i] == bus.wb_regDest) begin
                val[i] = bus.wb_value;
            end else begin
                val[i] = r[addr[i]];
            end
        end
    end
    assign bus.id_rsValue = rst ? '0 : val[0];
    assign bus.id_rtValue = rst ? '0 : val[1];
    assign bus.id_stall   = rst ? 1'b0 : (haz[0] | haz[1]);
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed vector table plus reset/write sequences for regfile
module tb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    regfile_if bus ();
    regfile dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  rs, rt;
        logic [4:0]  ex_d;
        logic [31:0] ex_v;
        logic        ex_ld;
        logic [4:0]  mem_d;
        logic [31:0] mem_v;
        logic [4:0]  wb_d;
        logic [31:0] wb_v;
        logic        chk_val;
        logic [31:0] exp_rs, exp_rt;
        logic        exp_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] ex_d, input logic [31:0] ex_v, input logic ex_ld,
                         input logic [4:0] mem_d, input logic [31:0] mem_v,
                         input logic [4:0] wb_d, input logic [31:0] wb_v);
        bus.id_rsAddr = rs;
        bus.id_rtAddr = rt;
        bus.ex_regDest = ex_d;
        bus.ex_value = ex_v;
        bus.ex_isLoad = ex_ld;
        bus.mem_regDest = mem_d;
        bus.mem_value = mem_v;
        bus.wb_regDest = wb_d;
        bus.wb_value = wb_v;
    endtask

    vec_t v [$];

    initial begin
        // live bypass inputs plus a write to r4 while reset is held
        drive(5, 4, 5, 32'h99, 0, 4, 32'h77, 4, 32'h55);
        @(negedge clk); #1;
        chk("rst_rs", bus.id_rsValue, 0);
        chk("rst_rt", bus.id_rtValue, 0);
        chk("rst_stall", {31'd0, bus.id_stall}, 0);
        @(negedge clk);
        bus.ex_isLoad = 1;
        #1;
        chk("rst_stall_load", {31'd0, bus.id_stall}, 0);
        @(negedge clk);
        rst = 0;
        drive(4, 5, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_wins_r4", bus.id_rsValue, 0);
        chk("post_rst_r5", bus.id_rtValue, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF);
        @(negedge clk);
        drive(5, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("write_r5", bus.id_rsValue, 32'hDEADBEEF);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_pulse_out", bus.id_rsValue, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_pulse_clr", bus.id_rsValue, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 7, 32'h11);

        // each vector is applied for one cycle; its wb write commits at the following edge
        v.push_back('{"r0_immut",   0, 0,  0, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h12345678, 1, 0, 0, 0});
        v.push_back('{"r7_stored",  7, 5,  0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 32'hDEADBEEF, 0});
        v.push_back('{"prio_ex",    5, 7,  7, 32'h44, 0, 7, 32'h33, 7, 32'h22, 1, 32'hDEADBEEF, 32'h44, 0});
        v.push_back('{"prio_mem",   5, 7,  0, 0, 0, 7, 32'h33, 7, 32'h22, 1, 32'hDEADBEEF, 32'h33, 0});
        v.push_back('{"prio_wb",    5, 7,  0, 0, 0, 0, 0, 7, 32'h22, 1, 32'hDEADBEEF, 32'h22, 0});
        v.push_back('{"prio_store", 5, 7,  0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'h22, 0});
        v.push_back('{"wb_bypass",  9, 0,  0, 0, 0, 0, 0, 9, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 0, 0});
        v.push_back('{"wb_persist", 9, 9,  0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 0});
        v.push_back('{"load_rt",    0, 3,  3, 32'hBAD, 1, 0, 0, 0, 0, 0, 0, 0, 1});
        v.push_back('{"load_fwd",   0, 3,  0, 0, 0, 3, 32'hCAFE0000, 0, 0, 1, 0, 32'hCAFE0000, 0});
        v.push_back('{"load_nomat", 5, 4,  3, 32'hBAD, 1, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0});
        v.push_back('{"load_rs",    6, 2,  6, 32'hBAD, 1, 0, 0, 0, 0, 0, 0, 0, 1});
        v.push_back('{"ex_fwd",    12, 12, 12, 32'hABCD, 0, 0, 0, 0, 0, 1, 32'hABCD, 32'hABCD, 0});
        v.push_back('{"mem_gt_wb",  3, 0,  0, 0, 0, 3, 32'h1, 3, 32'h2, 1, 32'h1, 0, 0});
        v.push_back('{"r3_wb",      3, 9,  0, 0, 0, 0, 0, 0, 0, 1, 32'h2, 32'hA5A5A5A5, 0});
        foreach (v[i]) begin
            @(negedge clk);
            drive(v[i].rs, v[i].rt, v[i].ex_d, v[i].ex_v, v[i].ex_ld,
                  v[i].mem_d, v[i].mem_v, v[i].wb_d, v[i].wb_v);
            #1;
            chk({v[i].name, "_stall"}, {31'd0, bus.id_stall}, {31'd0, v[i].exp_stall});
            if (v[i].chk_val) begin
                chk({v[i].name, "_rs"}, bus.id_rsValue, v[i].exp_rs);
                chk({v[i].name, "_rt"}, bus.id_rtValue, v[i].exp_rt);
            end
        end

        // reset mid-operation with live bypass, then storage must read cleared
        @(negedge clk);
        rst = 1;
        drive(7, 9, 7, 32'h44, 0, 9, 32'h33, 0, 0);
        #1;
        chk("mid_rst_rs", bus.id_rsValue, 0);
        chk("mid_rst_rt", bus.id_rtValue, 0);
        @(negedge clk);
        rst = 0;
        drive(7, 9, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_rst_r7", bus.id_rsValue, 0);
        chk("mid_rst_r9", bus.id_rtValue, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
